toy_memory: RTL and testbench



---
 rtl/toy_mem_pkg.sv | 26 ++
 rtl/toy_mem_array.sv | 39 +++
 rtl/toy_memory.sv | 144 ++++++++++++++
 tb/tb_toy_memory.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/toy_mem_pkg.sv
// Shared definitions for the toy memory: handshake states, default geometry,
// start of the write-protected region and a saturating counter helper.
package toy_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESP     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    localparam int          DEF_ADDR_W   = 8;
    localparam int          DEF_DATA_W   = 8;
    localparam logic [7:0]  DEF_ROM_BASE = 8'hF0;

    // Increment an 8-bit event counter, sticking at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/toy_mem_array.sv
// Storage array: 2^ADDR_W words, one synchronous write port and one
// synchronous (registered) read port. Contents and read register are not reset.
module toy_mem_array
    import toy_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_r;

    // Commit one word per edge when the write port is enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Capture the addressed word into the read register when a read is issued.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/toy_memory.sv
// Processor-facing memory with a level MEM_EN / pulse ACK handshake, a
// write-protected upper region, a preload port and saturating access counters.
module toy_memory
    import toy_mem_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] ROM_BASE = ADDR_W'(DEF_ROM_BASE)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_EN,
    input  logic              RORW,
    input  logic [ADDR_W-1:0] ADD,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              ERR,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADD,
    input  logic [DATA_W-1:0] LOAD_DATA,
    output logic              LOAD_ACK,
    output logic [7:0]        RD_CNT,
    output logic [7:0]        WR_CNT
);

    state_t            state_r;
    logic              ack_r;
    logic              err_r;
    logic              load_ack_r;
    logic [7:0]        rd_cnt_r;
    logic [7:0]        wr_cnt_r;
    logic              rd_seen_r;

    logic              accept_s;
    logic              load_accept_s;
    logic              rd_accept_s;
    logic              wr_commit_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] arr_rd_data_s;

    // Decode which request (if any) is taken at this edge; reset blocks all of them.
    always_comb begin
        accept_s      = 1'b0;
        load_accept_s = 1'b0;
        if (!RESET && (state_r == ST_IDLE)) begin
            accept_s      = MEM_EN;
            load_accept_s = !MEM_EN && LOAD_EN;
        end else begin
            accept_s      = 1'b0;
            load_accept_s = 1'b0;
        end
        rd_accept_s = accept_s && RORW;
        wr_commit_s = accept_s && !RORW && (ADD < ROM_BASE);
    end

    // Share the single write port: preload and processor writes never coincide
    // because a preload is only taken while MEM_EN is low.
    always_comb begin
        wr_en_s = wr_commit_s || load_accept_s;
        if (load_accept_s) begin
            wr_addr_s = LOAD_ADD;
            wr_data_s = LOAD_DATA;
        end else begin
            wr_addr_s = ADD;
            wr_data_s = WDATA;
        end
    end

    toy_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (CLK),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_accept_s),
        .rd_addr (ADD),
        .rd_data (arr_rd_data_s)
    );

    // Handshake FSM with registered pulses and counters; one access per MEM_EN assertion.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            load_ack_r <= 1'b0;
            rd_cnt_r   <= 8'h00;
            wr_cnt_r   <= 8'h00;
            rd_seen_r  <= 1'b0;
        end else begin
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            load_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (MEM_EN) begin
                        state_r <= ST_RESP;
                        ack_r   <= 1'b1;
                        if (RORW) begin
                            rd_cnt_r  <= sat_inc(rd_cnt_r);
                            rd_seen_r <= 1'b1;
                        end else if (ADD < ROM_BASE) begin
                            wr_cnt_r <= sat_inc(wr_cnt_r);
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else if (LOAD_EN) begin
                        load_ack_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (MEM_EN) begin
                        state_r <= ST_WAIT_LOW;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!MEM_EN) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // The array read register has no reset, so RDATA reads as zero until the
    // first read after reset has loaded it.
    assign RDATA    = rd_seen_r ? arr_rd_data_s : {DATA_W{1'b0}};
    assign ACK      = ack_r;
    assign ERR      = err_r;
    assign LOAD_ACK = load_ack_r;
    assign RD_CNT   = rd_cnt_r;
    assign WR_CNT   = wr_cnt_r;

endmodule

// File: tb/tb_toy_memory.sv
// Directed bench for toy_memory: a transaction-level model predicts every
// output each cycle, and directed sequences pin key values to literals.
module tb_toy_memory;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       MEM_EN = 1'b0;
    logic       RORW = 1'b0;
    logic [7:0] ADD = 8'h00;
    logic [7:0] WDATA = 8'h00;
    logic [7:0] RDATA;
    logic       ACK;
    logic       ERR;
    logic       LOAD_EN = 1'b0;
    logic [7:0] LOAD_ADD = 8'h00;
    logic [7:0] LOAD_DATA = 8'h00;
    logic       LOAD_ACK;
    logic [7:0] RD_CNT;
    logic [7:0] WR_CNT;

    int total = 0;
    int bad = 0;

    toy_memory dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .MEM_EN    (MEM_EN),
        .RORW      (RORW),
        .ADD       (ADD),
        .WDATA     (WDATA),
        .RDATA     (RDATA),
        .ACK       (ACK),
        .ERR       (ERR),
        .LOAD_EN   (LOAD_EN),
        .LOAD_ADD  (LOAD_ADD),
        .LOAD_DATA (LOAD_DATA),
        .LOAD_ACK  (LOAD_ACK),
        .RD_CNT    (RD_CNT),
        .WR_CNT    (WR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // "free" means the memory will take a new access: true after reset and
    // after MEM_EN has been observed low following an accepted access.
    logic [7:0] m_mem [256];
    bit         m_known [256];
    bit         m_free = 1'b0;
    bit         m_on = 1'b0;
    logic       e_ack, e_err, e_lack;
    logic [7:0] e_rdata, e_rd, e_wr;
    bit         e_rdata_known;

    always @(posedge CLK) begin
        if (RESET) begin
            m_free <= 1'b1; m_on <= 1'b1;
            e_ack <= 1'b0; e_err <= 1'b0; e_lack <= 1'b0;
            e_rdata <= 8'h00; e_rdata_known <= 1'b1;
            e_rd <= 8'h00; e_wr <= 8'h00;
        end else begin
            e_ack <= 1'b0; e_err <= 1'b0; e_lack <= 1'b0;
            if (m_free && MEM_EN) begin
                m_free <= 1'b0;
                e_ack  <= 1'b1;
                if (RORW) begin
                    e_rdata       <= m_mem[ADD];
                    e_rdata_known <= m_known[ADD];
                    e_rd          <= (e_rd == 8'hFF) ? 8'hFF : e_rd + 8'd1;
                end else if (ADD < 8'hF0) begin
                    m_mem[ADD]   <= WDATA;
                    m_known[ADD] <= 1'b1;
                    e_wr         <= (e_wr == 8'hFF) ? 8'hFF : e_wr + 8'd1;
                end else begin
                    e_err <= 1'b1;
                end
            end else if (m_free && LOAD_EN) begin
                m_mem[LOAD_ADD]   <= LOAD_DATA;
                m_known[LOAD_ADD] <= 1'b1;
                e_lack            <= 1'b1;
            end else if (!MEM_EN) begin
                m_free <= 1'b1;
            end
        end
    end

    // Compare every output with the model on each falling edge once reset has been seen.
    always @(negedge CLK) begin
        if (m_on) begin
            chk("m_ack", 32'(ACK), 32'(e_ack));
            chk("m_err", 32'(ERR), 32'(e_err));
            chk("m_load_ack", 32'(LOAD_ACK), 32'(e_lack));
            chk("m_rd_cnt", 32'(RD_CNT), 32'(e_rd));
            chk("m_wr_cnt", 32'(WR_CNT), 32'(e_wr));
            if (e_rdata_known) chk("m_rdata", 32'(RDATA), 32'(e_rdata));
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic access(input logic rw, input logic [7:0] a, input logic [7:0] d,
                          input int hold, output int acks, output int errs,
                          output int ack_at, output logic [7:0] rd_at_ack);
        acks = 0; errs = 0; ack_at = -1; rd_at_ack = 8'h00;
        MEM_EN = 1'b1; RORW = rw; ADD = a; WDATA = d;
        for (int i = 1; i <= hold + 2; i++) begin
            @(negedge CLK);
            if (ACK === 1'b1) begin
                acks++;
                if (ack_at < 0) begin ack_at = i; rd_at_ack = RDATA; end
            end
            if (ERR === 1'b1) errs++;
            if (i == hold) begin
                MEM_EN = 1'b0;
                ADD = ~a; WDATA = ~d; RORW = ~rw;
            end
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d, output int lat);
        lat = -1;
        LOAD_EN = 1'b1; LOAD_ADD = a; LOAD_DATA = d;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(negedge CLK);
            if (LOAD_ACK === 1'b1) lat = i;
        end
        LOAD_EN = 1'b0;
        @(negedge CLK);
    endtask

    int acks, errs, ack_at, lat;
    logic [7:0] rd;

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk("reset_rdata", 32'(RDATA), 32'h0);
        chk("reset_ack", 32'(ACK), 32'h0);
        chk("reset_rd_cnt", 32'(RD_CNT), 32'h0);
        chk("reset_wr_cnt", 32'(WR_CNT), 32'h0);
        RESET = 1'b0;
        @(negedge CLK);

        // Preload then read back
        load(8'h10, 8'hAA, lat);
        chk("preload_latency", 32'(lat), 32'd1);
        access(1'b1, 8'h10, 8'h00, 1, acks, errs, ack_at, rd);
        chk("read_ack_at", 32'(ack_at), 32'd1);
        chk("read_rdata", 32'(rd), 32'hAA);
        chk("read_rd_cnt", 32'(RD_CNT), 32'd1);

        // Write held for four cycles: one ACK only
        access(1'b0, 8'h05, 8'h3C, 4, acks, errs, ack_at, rd);
        chk("held_write_acks", 32'(acks), 32'd1);
        chk("held_write_wr_cnt", 32'(WR_CNT), 32'd1);
        access(1'b1, 8'h05, 8'h00, 1, acks, errs, ack_at, rd);
        chk("held_write_readback", 32'(rd), 32'h3C);

        // Write refused in the protected region
        load(8'hF4, 8'h77, lat);
        chk("rom_preload_latency", 32'(lat), 32'd1);
        access(1'b0, 8'hF4, 8'h00, 1, acks, errs, ack_at, rd);
        chk("rom_write_acks", 32'(acks), 32'd1);
        chk("rom_write_errs", 32'(errs), 32'd1);
        chk("rom_write_wr_cnt", 32'(WR_CNT), 32'd1);
        access(1'b1, 8'hF4, 8'h00, 1, acks, errs, ack_at, rd);
        chk("rom_readback", 32'(rd), 32'h77);
        chk("rom_readback_err", 32'(errs), 32'd0);

        // Preload competing with a processor read
        LOAD_EN = 1'b1; LOAD_ADD = 8'h20; LOAD_DATA = 8'h5A;
        MEM_EN = 1'b1; RORW = 1'b1; ADD = 8'h10;
        @(negedge CLK);
        chk("contend_ack", 32'(ACK), 32'h1);
        chk("contend_rdata", 32'(RDATA), 32'hAA);
        chk("contend_no_load_ack", 32'(LOAD_ACK), 32'h0);
        @(negedge CLK);
        chk("contend_no_load_ack2", 32'(LOAD_ACK), 32'h0);
        MEM_EN = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(negedge CLK);
            if (LOAD_ACK === 1'b1) lat = i;
        end
        chk("contend_load_latency", 32'(lat), 32'd2);
        LOAD_EN = 1'b0;
        @(negedge CLK);
        access(1'b1, 8'h20, 8'h00, 1, acks, errs, ack_at, rd);
        chk("contend_readback", 32'(rd), 32'h5A);

        // Reset during RESP with MEM_EN held
        MEM_EN = 1'b1; RORW = 1'b1; ADD = 8'h05;
        @(negedge CLK);
        chk("abort_ack_before", 32'(ACK), 32'h1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort_ack", 32'(ACK), 32'h0);
        chk("abort_rdata", 32'(RDATA), 32'h0);
        chk("abort_rd_cnt", 32'(RD_CNT), 32'h0);
        chk("abort_wr_cnt", 32'(WR_CNT), 32'h0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("reaccept_ack", 32'(ACK), 32'h1);
        chk("reaccept_rdata", 32'(RDATA), 32'h3C);
        chk("reaccept_rd_cnt", 32'(RD_CNT), 32'd1);
        MEM_EN = 1'b0;
        repeat (2) @(negedge CLK);

        // Read counter saturation
        for (int n = 0; n < 300; n++) begin
            access(1'b1, 8'h10, 8'h00, 1, acks, errs, ack_at, rd);
        end
        chk("rd_cnt_saturated", 32'(RD_CNT), 32'hFF);
        access(1'b1, 8'h10, 8'h00, 1, acks, errs, ack_at, rd);
        chk("rd_cnt_holds", 32'(RD_CNT), 32'hFF);
        chk("wr_cnt_after_reads", 32'(WR_CNT), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
